fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader_if.sv | 29 ++
 rtl/fifo_stream_reader.sv | 89 ++++++++
 tb/tb_fifo_stream_reader.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// Stream reader bus: pop side toward the upstream sync FIFO plus the valid/ready output stream.
interface fifo_stream_reader_if #(
  parameter int FIFO_WIDTH = 32
);
  logic                  fifo_empty;
  logic                  read_en;
  logic [FIFO_WIDTH-1:0] read_data;
  logic                  m_valid;
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    input  fifo_empty,
    input  read_data,
    input  m_ready,
    output read_en,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output read_data,
    output m_ready,
    input  read_en,
    input  m_valid,
    input  m_data
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Sync-FIFO to valid/ready stream adapter: 3-entry output buffer, read_en -> m_valid in 2 cycles, stalls hold the head word.
// Define FIFO_READER_STATS_EN to build the beat/stall counters; otherwise both read constant 0.
module fifo_stream_reader #(
  parameter int FIFO_PTR   = 10,
  parameter int FIFO_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 flush,
  fifo_stream_reader_if.master bus,
  output logic [31:0]          beat_count,
  output logic [31:0]          stall_count
);
  logic [FIFO_WIDTH-1:0] ob     [3];
  logic [FIFO_WIDTH-1:0] ob_nxt [3];
  logic [1:0]            ob_count;
  logic [1:0]            ob_count_nxt;
  logic [1:0]            wr_idx;
  logic                  inflight;
  logic                  armed;
  logic                  pop;
  logic                  cap;

  if (FIFO_PTR < 1) begin : g_bad_fifo_ptr
  end

  // Occupancy plus the in-flight word must fit in the buffer; m_ready is deliberately not consulted.
  assign bus.read_en = armed && !bus.fifo_empty && enable && !flush &&
                       (({1'b0, ob_count} + {2'b00, inflight}) <= 3'd2);
  assign bus.m_valid = (ob_count != 2'd0);
  assign bus.m_data  = ob[0];

  assign pop    = bus.m_valid && bus.m_ready && !flush;
  assign cap    = inflight && !flush;
  assign wr_idx = ob_count - {1'b0, pop};

  always_comb begin
    ob_nxt       = ob;
    ob_count_nxt = ob_count;
    if (flush) begin
      ob_count_nxt = 2'd0;
    end else begin
      if (pop) begin
        ob_nxt[0] = ob[1];
        ob_nxt[1] = ob[2];
      end
      if (cap) begin
        case (wr_idx)
          2'd0:    ob_nxt[0] = bus.read_data;
          2'd1:    ob_nxt[1] = bus.read_data;
          2'd2:    ob_nxt[2] = bus.read_data;
          default: ;
        endcase
      end
      ob_count_nxt = ob_count + {1'b0, cap} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ob_count <= 2'd0;
      inflight <= 1'b0;
      armed    <= 1'b0;
      for (int i = 0; i < 3; i++) ob[i] <= '0;
    end else begin
      ob_count <= ob_count_nxt;
      inflight <= bus.read_en;
      armed    <= 1'b1;
      ob       <= ob_nxt;
    end
  end

`ifdef FIFO_READER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count  <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      beat_count  <= beat_count + {31'd0, pop};
      stall_count <= stall_count + {31'd0, (bus.m_valid && !bus.m_ready)};
    end
  end
`else
  assign beat_count  = 32'd0;
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomised and directed bench for fifo_stream_reader against a queue-based model of the output buffer.
module tb_fifo_stream_reader;
  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] beat_count;
  logic [31:0] stall_count;

  fifo_stream_reader_if #(.FIFO_WIDTH(W)) bus ();

  fifo_stream_reader #(.FIFO_PTR(10), .FIFO_WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .flush       (flush),
    .bus         (bus),
    .beat_count  (beat_count),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [W-1:0] fq[$];
  logic [W-1:0] mq[$];
  logic [W-1:0] delivered[$];
  logic [W-1:0] fetched;
  bit           fetched_vld;
  bit           m_infl;
  logic [W-1:0] m_infl_word;
  bit           armed;
  logic [31:0]  m_beats;
  logic [31:0]  m_stalls;
  bit           last_re, last_mv, last_hs;
  logic [W-1:0] last_md;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: apply inputs at the falling edge, sample just after, then advance the model.
  task automatic cycle(input bit en, input bit fl, input bit rdy);
    bit exp_re, exp_mv, hs;
    @(negedge clk);
    enable         = en;
    flush          = fl;
    bus.m_ready    = rdy;
    bus.fifo_empty = (fq.size() == 0);
    bus.read_data  = fetched_vld ? fetched : W'($urandom);
    #1;
    exp_re = rst_n && armed && (fq.size() != 0) && en && !fl && ((mq.size() + m_infl) <= 2);
    exp_mv = (mq.size() != 0);
    check("read_en", bus.read_en, exp_re);
    check("m_valid", bus.m_valid, exp_mv);
    if (exp_mv) check("m_data", bus.m_data, mq[0]);
`ifdef FIFO_READER_STATS_EN
    check("beat_count", beat_count, m_beats);
    check("stall_count", stall_count, m_stalls);
`else
    check("beat_count", beat_count, 0);
    check("stall_count", stall_count, 0);
`endif
    hs      = exp_mv && rdy && !fl;
    last_re = bus.read_en;
    last_mv = bus.m_valid;
    last_md = bus.m_data;
    last_hs = hs;
    if (rst_n) begin
      m_beats  += {31'd0, hs};
      m_stalls += {31'd0, (exp_mv && !rdy)};
      if (fl) begin
        mq.delete();
      end else begin
        if (hs) delivered.push_back(mq.pop_front());
        if (m_infl) mq.push_back(m_infl_word);
      end
      if (bus.read_en && fq.size() != 0) begin
        fetched_vld = 1'b1;
        fetched     = fq.pop_front();
      end else begin
        fetched_vld = 1'b0;
      end
      m_infl      = exp_re;
      m_infl_word = fetched;
      armed       = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst read_en", bus.read_en, 0);
    check("rst m_valid", bus.m_valid, 0);
    check("rst m_data", bus.m_data, 0);
    check("rst beat_count", beat_count, 0);
    check("rst stall_count", stall_count, 0);
    mq.delete();
    m_infl      = 1'b0;
    armed       = 1'b0;
    fetched_vld = 1'b0;
    m_beats     = 32'd0;
    m_stalls    = 32'd0;
    cycle(1, 0, 1);
    cycle(1, 0, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    bit   re_log[8];
    bit   mv_log[8];
    logic [W-1:0] md_log[8];
    int   cnt, first_beat, last_beat, run, max_run;
    bit   en, fl, rdy;

    bus.m_ready    = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.read_data  = '0;
    m_beats = 0; m_stalls = 0; fetched = '0;

    // Three-word preload, free-flowing output
    fq.push_back(32'h11); fq.push_back(32'h22); fq.push_back(32'h33);
    do_reset();
    cycle(1, 0, 1);
    for (int t = 0; t < 7; t++) begin
      cycle(1, 0, 1);
      re_log[t] = last_re; mv_log[t] = last_mv; md_log[t] = last_md;
    end
    check("pre re0", re_log[0], 1); check("pre re2", re_log[2], 1); check("pre re3", re_log[3], 0);
    check("pre mv1", mv_log[1], 0); check("pre mv2", mv_log[2], 1); check("pre mv4", mv_log[4], 1);
    check("pre mv5", mv_log[5], 0);
    check("pre d0", md_log[2], 32'h11); check("pre d1", md_log[3], 32'h22); check("pre d2", md_log[4], 32'h33);

    // Eight words with the sink stalled, then released
    delivered.delete();
    for (int i = 0; i < 8; i++) fq.push_back(32'h100 + i);
    cnt = 0;
    for (int t = 0; t < 10; t++) begin
      cycle(1, 0, 0);
      cnt += int'(last_re);
    end
    check("stall read pulses", cnt, 3);
    check("stall head valid", last_mv, 1);
    check("stall head word", last_md, 32'h100);
    first_beat = -1; last_beat = -1;
    for (int t = 0; t < 14; t++) begin
      cycle(1, 0, 1);
      if (last_hs) begin
        if (first_beat < 0) first_beat = t;
        last_beat = t;
      end
    end
    check("restart beats", delivered.size(), 8);
    check("restart span", last_beat - first_beat, 7);
    for (int i = 0; i < 8 && i < delivered.size(); i++) check("restart order", delivered[i], 32'h100 + i);

    // 100-word stream
    do_reset();
    delivered.delete();
    for (int i = 0; i < 100; i++) fq.push_back($urandom);
    cycle(1, 0, 1);
    run = 0; max_run = 0;
    for (int t = 0; t < 106; t++) begin
      cycle(1, 0, 1);
      run = last_re ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    check("stream read run", max_run, 100);
    check("stream delivered", delivered.size(), 100);
`ifdef FIFO_READER_STATS_EN
    check("stream beat_count", beat_count, 100);
    check("stream stall_count", stall_count, 0);
`endif

    // Flush with buffered and in-flight words
    delivered.delete();
    for (int i = 0; i < 10; i++) fq.push_back(32'h200 + i);
    for (int t = 0; t < 3; t++) cycle(1, 0, 0);
    cycle(1, 1, 0);
    cycle(1, 0, 1);
    check("flush m_valid", last_mv, 0);
    for (int t = 0; t < 12; t++) cycle(1, 0, 1);
    check("flush survivors", delivered.size(), 7);
    if (delivered.size() > 0) check("flush resume word", delivered[0], 32'h203);

    // Enable dropped right after a read
    delivered.delete();
    for (int i = 0; i < 4; i++) fq.push_back(32'h300 + i);
    cycle(1, 0, 1);
    check("enable read", last_re, 1);
    cnt = 0;
    for (int t = 0; t < 6; t++) begin
      cycle(0, 0, 1);
      cnt += int'(last_re);
    end
    check("enable off reads", cnt, 0);
    check("enable off delivered", delivered.size(), 1);
    if (delivered.size() > 0) check("enable off word", delivered[0], 32'h300);

    // Random traffic with a mid-stream reset
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 3) == 0) fq.push_back($urandom);
      en  = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 4) < 3);
      cycle(en, fl, rdy);
      if (t == 300) do_reset();
    end
    for (int t = 0; t < 10; t++) cycle(0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
